// File: rtl/icache_pkg.sv
// icache_pkg: shared constants, FSM encoding and sizing helper for the fetch-side instruction cache.
package icache_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    typedef enum logic {IC_IDLE, IC_REFILL} ic_state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: valid/tag/data arrays with one combinational read port, one write port and clear-all.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = clog2(LINES),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data,
    input  logic             i_clr
);
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag [LINES];
    logic [31:0]      r_data [LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

    // clear beats a simultaneous fill: the data lands but the line stays invalid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_valid <= '0;
        else if (i_clr) r_valid <= '0;
        else if (i_we) r_valid[i_wr_idx] <= 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end
endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped one-word-line instruction cache with zero-latency hits and req/ack refill.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_pc,
    input  logic             i_inv,
    output logic [31:0]      o_instr,
    output logic             o_stall,
    output logic             o_mem_req,
    output logic [31:0]      o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [31:0]      i_mem_rdata,
    output logic [CNT_W-1:0] o_hit_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);
    localparam int IDX_W = clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    ic_state_t        r_state, w_next;
    logic [31:0]      r_maddr;
    logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;
    logic             w_valid, w_hit, w_start, w_fill;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_data;

    icache_line_store #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_store (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rd_idx  (i_pc[IDX_W+1:2]),
        .o_rd_valid(w_valid),
        .o_rd_tag  (w_tag),
        .o_rd_data (w_data),
        .i_we      (w_fill),
        .i_wr_idx  (r_maddr[IDX_W+1:2]),
        .i_wr_tag  (r_maddr[31:IDX_W+2]),
        .i_wr_data (i_mem_rdata),
        .i_clr     (i_inv)
    );

    assign w_hit      = w_valid && (w_tag == i_pc[31:IDX_W+2]) && (r_state == IC_IDLE);
    assign o_instr    = w_hit ? w_data : NOP_INSTR;
    assign o_stall    = !w_hit;
    assign o_mem_req  = (r_state == IC_REFILL);
    assign o_mem_addr = r_maddr;
    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;

    always_comb begin
        w_start = (r_state == IC_IDLE) && !w_hit && !i_inv;
        w_fill  = (r_state == IC_REFILL) && i_mem_ack;
        w_next  = w_start ? IC_REFILL : w_fill ? IC_IDLE : r_state;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IC_IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_maddr    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_start) r_maddr <= i_pc & ~32'h3;
            if (w_hit && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (w_start && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: directed scenarios checked against a behavioural cache model plus literal expectations.
module tb_icache_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        inv = 1'b0;
    logic [31:0] instr, mem_addr, mem_rdata, hit_cnt, miss_cnt;
    logic        stall, mem_req, mem_ack;
    logic        ack_tie = 1'b0;
    int          lat = 3;
    int          rc;
    int          tests = 0;
    int          fails = 0;

    icache_fetch dut (
        .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_inv(inv),
        .o_instr(instr), .o_stall(stall), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0040_0000) ? 32'h2008_0005 : ~a;
    endfunction

    // backing memory: acks after lat request cycles, or every cycle when ack_tie is set
    assign mem_rdata = mem_word(mem_addr);
    assign mem_ack   = ack_tie | (mem_req && rc == lat - 1);
    always @(posedge clk or posedge rst) begin
        if (rst) rc <= 0;
        else rc <= (mem_req && !mem_ack) ? rc + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: per-line word address, refill in flight, counters
    bit          m_valid [16];
    logic [29:0] m_waddr [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [31:0] m_addr;
    logic [31:0] m_hits, m_misses;

    function automatic bit m_hit();
        int i = int'(pc[5:2]);
        return !m_busy && m_valid[i] && m_waddr[i] == pc[31:2];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_addr = 0; m_hits = 0; m_misses = 0;
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end else begin
            bit h;
            h = m_hit();
            if (h && m_hits != 32'hFFFF_FFFF) m_hits++;
            if (m_busy) begin
                if (mem_ack) begin
                    m_data[m_addr[5:2]]  = mem_word(m_addr);
                    m_waddr[m_addr[5:2]] = m_addr[31:2];
                    m_valid[m_addr[5:2]] = 1;
                    m_busy = 0;
                end
            end else if (!h && !inv) begin
                m_busy = 1;
                m_addr = {pc[31:2], 2'b00};
                if (m_misses != 32'hFFFF_FFFF) m_misses++;
            end
            if (inv) for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end
    end

    always @(negedge clk) begin
        bit h;
        h = m_hit();
        chk("instr", instr, h ? m_data[pc[5:2]] : 32'h0);
        chk("stall", {31'b0, stall}, {31'b0, !h});
        chk("mem_req", {31'b0, mem_req}, {31'b0, m_busy});
        chk("mem_addr", mem_addr, m_addr);
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [31:0] p);
        pc = p; inv = 0; ack_tie = 0; rst = 1;
        cyc();
        rst = 0;
        #1;
    endtask

    task automatic wait_hit();
        for (int i = 0; i < 20 && stall; i++) cyc();
        #1;
        chk("wait_hit", {31'b0, stall}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // cold miss with 3-cycle memory
        lat = 3;
        do_reset(32'h0040_0000);
        chk("rst_stall", {31'b0, stall}, 32'h1);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_miss", miss_cnt, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_req", {31'b0, mem_req}, 32'h1);
            chk("t1_addr", mem_addr, 32'h0040_0000);
            chk("t1_stall", {31'b0, stall}, 32'h1);
            chk("t1_instr", instr, 32'h0);
        end
        cyc();
        chk("t1_hit_instr", instr, 32'h2008_0005);
        chk("t1_hit_stall", {31'b0, stall}, 32'h0);
        chk("t1_miss_cnt", miss_cnt, 32'h1);
        // zero-wait ack
        pc = 32'h8; ack_tie = 1; #1;
        chk("t2_stall_a", {31'b0, stall}, 32'h1);
        cyc();
        chk("t2_stall_b", {31'b0, stall}, 32'h1);
        chk("t2_req_b", {31'b0, mem_req}, 32'h1);
        cyc();
        chk("t2_hit", {31'b0, stall}, 32'h0);
        chk("t2_instr", instr, ~32'h8);
        chk("t2_hc0", hit_cnt, 32'h0);
        cyc();
        chk("t2_hc1", hit_cnt, 32'h1);
        cyc();
        chk("t2_hc2", hit_cnt, 32'h2);
        chk("t2_miss", miss_cnt, 32'h2);
        ack_tie = 0;
        // conflict on line 0
        lat = 1;
        do_reset(32'h0);
        wait_hit();
        chk("t3_i0", instr, ~32'h0);
        pc = 32'h40; #1;
        chk("t3_miss40", {31'b0, stall}, 32'h1);
        wait_hit();
        chk("t3_i40", instr, ~32'h40);
        pc = 32'h0; #1;
        chk("t3_remiss", {31'b0, stall}, 32'h1);
        wait_hit();
        chk("t3_i0b", instr, ~32'h0);
        chk("t3_miss_cnt", miss_cnt, 32'h3);
        // inv coincident with the fill ack
        lat = 3;
        do_reset(32'h20);
        wait_hit();
        pc = 32'h10; #1;
        cyc(); cyc(); cyc();
        chk("t4_req", {31'b0, mem_req}, 32'h1);
        inv = 1;
        cyc();
        inv = 0; #1;
        chk("t4_idle_req", {31'b0, mem_req}, 32'h0);
        chk("t4_remiss", {31'b0, stall}, 32'h1);
        cyc();
        chk("t4_newreq", {31'b0, mem_req}, 32'h1);
        chk("t4_newaddr", mem_addr, 32'h10);
        wait_hit();
        chk("t4_instr", instr, ~32'h10);
        pc = 32'h20; #1;
        chk("t4_other_inv", {31'b0, stall}, 32'h1);
        // reset in the middle of a refill
        lat = 5;
        do_reset(32'h30);
        cyc(); cyc(); #1;
        chk("t5_req_pre", {31'b0, mem_req}, 32'h1);
        rst = 1; #1;
        chk("t5_req_async", {31'b0, mem_req}, 32'h0);
        chk("t5_hc", hit_cnt, 32'h0);
        chk("t5_mc", miss_cnt, 32'h0);
        ack_tie = 1;
        cyc(); cyc();
        inv = 1; rst = 0;
        cyc();
        chk("t5_req_post", {31'b0, mem_req}, 32'h0);
        inv = 0; ack_tie = 0; #1;
        chk("t5_stall", {31'b0, stall}, 32'h1);
        chk("t5_instr", instr, 32'h0);
        wait_hit();
        chk("t5_fill", instr, ~32'h30);
        chk("t5_mc1", miss_cnt, 32'h1);
        // pc moves while a refill is outstanding
        lat = 3;
        do_reset(32'h4);
        cyc();
        pc = 32'h100;
        cyc(); cyc(); cyc(); #1;
        chk("t6_idle", {31'b0, mem_req}, 32'h0);
        chk("t6_stall", {31'b0, stall}, 32'h1);
        cyc();
        chk("t6_req", {31'b0, mem_req}, 32'h1);
        chk("t6_addr", mem_addr, 32'h100);
        wait_hit();
        chk("t6_i100", instr, ~32'h100);
        pc = 32'h4; #1;
        chk("t6_hit4", {31'b0, stall}, 32'h0);
        chk("t6_i4", instr, ~32'h4);
        chk("t6_mc", miss_cnt, 32'h2);
        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
